// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite master: 10-bit address, byte data.
// Accepts one command at a time and issues a SINGLE, INCR4, WRAP4 or INCR8
// burst with pipelined address and data phases. Read beats and a completion
// pulse go back to the requester.
// Ports:
//   hclk, hreset                     clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/burst command handshake and fields
//   wd_pop, wd_data                  show-ahead write-data FIFO interface
//   rd_valid, rd_data                read beat return
//   done, err                        completion pulse, error qualifier
//   haddr..hmastlock, hwdata         AHB master outputs
//   hready, hresp, hrdata            AHB slave-mux responses
module ahb_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [1:0]  cmd_burst,
  output logic        wd_pop,
  input  logic [7:0]  wd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic [9:0]  haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [7:0]  hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [7:0]  hrdata
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 3;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   haddr_q;
  logic [1:0]      htrans_q;
  logic            hwrite_q;
  logic [2:0]      hburst_q;
  logic [DW-1:0]   hwdata_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   last_q;
  logic            dphase_q;
  logic            dwrite_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            done_q;
  logic            err_q;

  logic [AW-1:0]   addr_nxt;
  logic            err_first;

  // WRAP4 wraps within its 4-byte block; INCR rolls over the 10-bit space.
  assign addr_nxt = (hburst_q == HBURST_WRAP4)
                  ? {haddr_q[AW-1:2], 2'(haddr_q[1:0] + 2'd1)}
                  : AW'(haddr_q + AW'(1));

  // First cycle of a two-cycle ERROR response on an outstanding data phase.
  assign err_first = dphase_q && hresp && !hready;

  assign cmd_ready = (state_q == S_IDLE) && !hreset;
  // Pop when a write address phase is accepted; hwdata takes wd_data at that edge.
  assign wd_pop    = !hreset && hready && hwrite_q && (htrans_q != TRANS_IDLE);

  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hburst    = hburst_q;
  assign hwdata    = hwdata_q;
  assign hsize     = 3'b000;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  // Burst sequencer, data-phase tracking and requester return path.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TRANS_IDLE;
      hwrite_q   <= 1'b0;
      hburst_q   <= HBURST_SINGLE;
      hwdata_q   <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      dphase_q   <= 1'b0;
      dwrite_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      if (wd_pop) begin
        hwdata_q <= wd_data;
      end

      // A data phase follows every accepted non-IDLE address phase.
      if (hready) begin
        dphase_q <= (htrans_q != TRANS_IDLE);
        dwrite_q <= hwrite_q;
      end

      if (hready && dphase_q && !dwrite_q && !hresp) begin
        rd_data_q  <= hrdata;
        rd_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            haddr_q  <= cmd_addr;
            htrans_q <= TRANS_NONSEQ;
            hwrite_q <= cmd_write;
            beat_q   <= '0;
            state_q  <= S_ADDR;
            case (cmd_burst)
              2'b00:   begin hburst_q <= HBURST_SINGLE; last_q <= BW'(0); end
              2'b01:   begin hburst_q <= HBURST_INCR4;  last_q <= BW'(3); end
              2'b10:   begin hburst_q <= HBURST_WRAP4;  last_q <= BW'(3); end
              default: begin hburst_q <= HBURST_INCR8;  last_q <= BW'(7); end
            endcase
          end
        end
        S_ADDR, S_BURST: begin
          if (err_first) begin
            htrans_q <= TRANS_IDLE;
            dphase_q <= 1'b0;
            state_q  <= S_ERR;
          end else if (hready) begin
            if (beat_q == last_q) begin
              htrans_q <= TRANS_IDLE;
              state_q  <= S_LAST;
            end else begin
              beat_q   <= BW'(beat_q + BW'(1));
              haddr_q  <= addr_nxt;
              htrans_q <= TRANS_SEQ;
              state_q  <= S_BURST;
            end
          end
        end
        S_LAST: begin
          if (err_first) begin
            dphase_q <= 1'b0;
            state_q  <= S_ERR;
          end else if (hready) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          // Second error cycle: report the aborted command.
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          htrans_q <= TRANS_IDLE;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: per-command slave response tables, a
// per-cycle log sampled on the falling edge, and hand-computed expectations.
module tb_ahb_master;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [9:0] cmd_addr;
  logic [1:0] cmd_burst;
  logic       wd_pop;
  logic [7:0] wd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done, err;
  logic [9:0] haddr;
  logic [1:0] htrans;
  logic       hwrite;
  logic [2:0] hsize, hburst;
  logic [3:0] hprot;
  logic       hmastlock;
  logic [7:0] hwdata;
  logic       hready, hresp;
  logic [7:0] hrdata;

  always #5 hclk = ~hclk;

  ahb_master #(.HPROT_VAL(4'b0011)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
    .wd_pop(wd_pop), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave response / reset tables indexed by cycle offset from command accept.
  logic       rdy_t [32];
  logic       rsp_t [32];
  logic       rst_t [32];
  logic [7:0] rdat_t[32];
  logic [7:0] wq    [8];
  int         widx;

  // Per-cycle observation log.
  logic [1:0] s_trans[32];
  logic [9:0] s_addr [32];
  logic [2:0] s_burst[32];
  logic       s_pop  [32];
  logic       s_rv   [32];
  logic       s_done [32];
  logic       s_err  [32];
  logic       s_rdy  [32];
  logic [7:0] s_wd   [32];
  logic [7:0] s_rd   [32];

  task automatic clear_tabs();
    for (int i = 0; i < 32; i++) begin
      rdy_t[i] = 1'b1; rsp_t[i] = 1'b0; rst_t[i] = 1'b0; rdat_t[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) wq[i] = 8'h00;
  endtask

  task automatic run(input logic w, input logic [9:0] a, input logic [1:0] b, input int ncyc);
    widx = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge hclk); #1;
      cmd_valid = (k == 0);
      cmd_write = w;
      cmd_addr  = a;
      cmd_burst = b;
      hready    = rdy_t[k];
      hresp     = rsp_t[k];
      hrdata    = rdat_t[k];
      hreset    = rst_t[k];
      wd_data   = (widx < 8) ? wq[widx] : 8'h00;
      @(negedge hclk);
      s_trans[k] = htrans;  s_addr[k] = haddr;   s_burst[k] = hburst;
      s_pop[k]   = wd_pop;  s_rv[k]   = rd_valid; s_done[k] = done;
      s_err[k]   = err;     s_rdy[k]  = cmd_ready; s_wd[k]  = hwdata;
      s_rd[k]    = rd_data;
      if (wd_pop) widx++;
    end
  endtask

  function automatic int count_pop(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(s_pop[i]);
    return c;
  endfunction

  function automatic int count_rv(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(s_rv[i]);
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(s_done[i]);
    return c;
  endfunction

  logic [9:0] ea[4];

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_burst = '0; wd_data = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_htrans", 32'(htrans), 32'h0);
    check_eq("rst_haddr", 32'(haddr), 32'h0);
    check_eq("rst_hwdata", 32'(hwdata), 32'h0);
    check_eq("rst_rd_data", 32'(rd_data), 32'h0);
    check_eq("rst_flags", {28'h0, rd_valid, done, err, wd_pop}, 32'h0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check_eq("rst_hburst", 32'(hburst), 32'h0);
    check_eq("consts", {21'h0, hsize, hprot, hmastlock}, {21'h0, 3'b000, 4'b0011, 1'b0});
    @(posedge hclk); #1 hreset = 1'b0;
    @(negedge hclk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // SINGLE write 0x005 / 0xA5
    clear_tabs(); wq[0] = 8'hA5;
    run(1'b1, 10'h005, 2'b00, 6);
    check_eq("t1_ready_T", 32'(s_rdy[0]), 32'h1);
    check_eq("t1_htrans", 32'(s_trans[1]), 32'h2);
    check_eq("t1_haddr", 32'(s_addr[1]), 32'h005);
    check_eq("t1_hburst", 32'(s_burst[1]), 32'h0);
    check_eq("t1_pop_T1", 32'(s_pop[1]), 32'h1);
    check_eq("t1_pops", 32'(count_pop(6)), 32'h1);
    check_eq("t1_hwdata", 32'(s_wd[2]), 32'hA5);
    check_eq("t1_idle_T2", 32'(s_trans[2]), 32'h0);
    check_eq("t1_done_T2", 32'(s_done[2]), 32'h0);
    check_eq("t1_done_T3", 32'(s_done[3]), 32'h1);
    check_eq("t1_err", 32'(s_err[3]), 32'h0);
    check_eq("t1_ready_T2", 32'(s_rdy[2]), 32'h0);
    check_eq("t1_ready_T3", 32'(s_rdy[3]), 32'h1);

    // INCR4 read across the top of the address space
    clear_tabs();
    rdat_t[2] = 8'h11; rdat_t[3] = 8'h22; rdat_t[4] = 8'h33; rdat_t[5] = 8'h44;
    run(1'b0, 10'h3FE, 2'b01, 8);
    ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_haddr%0d", i), 32'(s_addr[1+i]), 32'(ea[i]));
      check_eq($sformatf("t2_htrans%0d", i), 32'(s_trans[1+i]), (i == 0) ? 32'h2 : 32'h3);
      check_eq($sformatf("t2_rv%0d", i), 32'(s_rv[3+i]), 32'h1);
      check_eq($sformatf("t2_rd%0d", i), 32'(s_rd[3+i]), 32'(8'h11 * (i + 1)));
    end
    check_eq("t2_hburst", 32'(s_burst[1]), 32'h3);
    check_eq("t2_idle_T5", 32'(s_trans[5]), 32'h0);
    check_eq("t2_done_T5", 32'(s_done[5]), 32'h0);
    check_eq("t2_done_T6", 32'(s_done[6]), 32'h1);
    check_eq("t2_rv_count", 32'(count_rv(8)), 32'h4);
    check_eq("t2_pops", 32'(count_pop(8)), 32'h0);

    // WRAP4 write at 0x00E
    clear_tabs();
    wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03; wq[3] = 8'h04;
    run(1'b1, 10'h00E, 2'b10, 8);
    ea[0] = 10'h00E; ea[1] = 10'h00F; ea[2] = 10'h00C; ea[3] = 10'h00D;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_haddr%0d", i), 32'(s_addr[1+i]), 32'(ea[i]));
      check_eq($sformatf("t3_pop%0d", i), 32'(s_pop[1+i]), 32'h1);
      check_eq($sformatf("t3_hwdata%0d", i), 32'(s_wd[2+i]), 32'(i + 1));
    end
    check_eq("t3_hburst", 32'(s_burst[1]), 32'h2);
    check_eq("t3_pops", 32'(count_pop(8)), 32'h4);
    check_eq("t3_done_T6", 32'(s_done[6]), 32'h1);

    // INCR8 read with two wait states on beat 3 data phase
    clear_tabs();
    rdy_t[5] = 1'b0; rdy_t[6] = 1'b0;
    rdat_t[2] = 8'h80; rdat_t[3] = 8'h81; rdat_t[4] = 8'h82;
    rdat_t[5] = 8'hEE; rdat_t[6] = 8'hEE; rdat_t[7] = 8'h83;
    rdat_t[8] = 8'h84; rdat_t[9] = 8'h85; rdat_t[10] = 8'h86; rdat_t[11] = 8'h87;
    run(1'b0, 10'h100, 2'b11, 15);
    check_eq("t4_hburst", 32'(s_burst[1]), 32'h5);
    check_eq("t4_haddr_w0", 32'(s_addr[5]), 32'h104);
    check_eq("t4_haddr_w1", 32'(s_addr[6]), 32'h104);
    check_eq("t4_haddr_w2", 32'(s_addr[7]), 32'h104);
    check_eq("t4_htrans_w", 32'(s_trans[6]), 32'h3);
    check_eq("t4_rv_w0", 32'(s_rv[6]), 32'h0);
    check_eq("t4_rv_w1", 32'(s_rv[7]), 32'h0);
    check_eq("t4_rd_hold", 32'(s_rd[7]), 32'h82);
    check_eq("t4_rv_b3", 32'(s_rv[8]), 32'h1);
    check_eq("t4_rd_b3", 32'(s_rd[8]), 32'h83);
    check_eq("t4_haddr_b7", 32'(s_addr[10]), 32'h107);
    check_eq("t4_idle_last", 32'(s_trans[11]), 32'h0);
    check_eq("t4_rd_b7", 32'(s_rd[12]), 32'h87);
    check_eq("t4_rv_count", 32'(count_rv(15)), 32'h8);
    check_eq("t4_done_T10", 32'(s_done[10]), 32'h0);
    check_eq("t4_done_T12", 32'(s_done[12]), 32'h1);
    check_eq("t4_done_count", 32'(count_done(15)), 32'h1);

    // INCR4 write, ERROR on beat 1
    clear_tabs();
    wq[0] = 8'hD0; wq[1] = 8'hD1; wq[2] = 8'hD2; wq[3] = 8'hD3;
    rsp_t[3] = 1'b1; rdy_t[3] = 1'b0; rsp_t[4] = 1'b1; rdy_t[4] = 1'b1;
    run(1'b1, 10'h020, 2'b01, 8);
    check_eq("t5_htrans_e0", 32'(s_trans[3]), 32'h3);
    check_eq("t5_haddr_e0", 32'(s_addr[3]), 32'h022);
    check_eq("t5_pop_e0", 32'(s_pop[3]), 32'h0);
    check_eq("t5_hwdata_e0", 32'(s_wd[3]), 32'hD1);
    for (int k = 4; k < 8; k++)
      check_eq($sformatf("t5_htrans_k%0d", k), 32'(s_trans[k]), 32'h0);
    check_eq("t5_pops", 32'(count_pop(8)), 32'h2);
    check_eq("t5_done_T4", 32'(s_done[4]), 32'h0);
    check_eq("t5_done_T5", 32'(s_done[5]), 32'h1);
    check_eq("t5_err_T5", 32'(s_err[5]), 32'h1);
    check_eq("t5_ready_T5", 32'(s_rdy[5]), 32'h1);
    check_eq("t5_done_count", 32'(count_done(8)), 32'h1);

    // Reset in the middle of an INCR8 read, then a SINGLE write
    clear_tabs();
    rst_t[3] = 1'b1;
    run(1'b0, 10'h200, 2'b11, 8);
    check_eq("t6_htrans_pre", 32'(s_trans[3]), 32'h3);
    check_eq("t6_ready_rst", 32'(s_rdy[3]), 32'h0);
    check_eq("t6_htrans_post", 32'(s_trans[4]), 32'h0);
    check_eq("t6_haddr_post", 32'(s_addr[4]), 32'h0);
    check_eq("t6_rv_post", 32'(s_rv[4]), 32'h0);
    check_eq("t6_no_done", 32'(count_done(8)), 32'h0);
    check_eq("t6_ready_post", 32'(s_rdy[4]), 32'h1);

    clear_tabs(); wq[0] = 8'h5A;
    run(1'b1, 10'h3FF, 2'b00, 6);
    check_eq("t7_haddr", 32'(s_addr[1]), 32'h3FF);
    check_eq("t7_htrans", 32'(s_trans[1]), 32'h2);
    check_eq("t7_hwdata", 32'(s_wd[2]), 32'h5A);
    check_eq("t7_done", 32'(s_done[3]), 32'h1);
    check_eq("t7_err", 32'(s_err[3]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- Single-outstanding AHB-Lite master that drives the existing AHB slaves: 10-bit address, byte data.
- Accepts one command at a time from a local requester (FPGA control logic, switch/button front end).
- Issues SINGLE, INCR4, WRAP4 or INCR8 transfers with correctly pipelined address and data phases.
- Returns read data and a completion/error pulse to the requester.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on hprot (non-cacheable, non-bufferable, privileged data access).

Ports:
- hclk  input  1  system clock; all logic on rising edge.
- hreset  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master can accept a command.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  10  start address.
- cmd_burst  input  2  00 SINGLE, 01 INCR4, 10 WRAP4, 11 INCR8.
- wd_pop  output  1  one-cycle pulse: wd_data consumed this cycle.
- wd_data  input  8  next write beat; must be valid whenever wd_pop is high (show-ahead FIFO).
- rd_valid  output  1  one-cycle pulse: rd_data holds a read beat.
- rd_data  output  8  captured read beat.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  qualifies done: 1 = terminated by ERROR response.
- haddr  output  10  AHB address.
- htrans  output  2  00 IDLE, 10 NONSEQ, 11 SEQ; BUSY is never issued.
- hwrite  output  1  AHB direction.
- hsize  output  3  constant 3'b000 (byte).
- hburst  output  3  000 / 011 / 010 / 101 for SINGLE / INCR4 / WRAP4 / INCR8.
- hprot  output  4  HPROT_VAL.
- hmastlock  output  1  constant 0.
- hwdata  output  8  write data, data phase.
- hready  input  1  transfer-done from slave mux.
- hresp  input  1  0 OKAY, 1 ERROR.
- hrdata  input  8  read data, data phase.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values (hreset sampled high at a clock edge):
  - state = IDLE, htrans = 00, haddr = 0, hwrite = 0, hburst = 000, hwdata = 0.
  - rd_data = 0; rd_valid, done, err, wd_pop all 0.
  - cmd_ready = 0 while hreset is high.
- Reset mid-burst aborts at once: htrans = IDLE on the next edge, no done pulse.
- cmd_ready = 1 only in state IDLE with hreset low. A command is accepted on cmd_valid & cmd_ready; cmd fields are registered.
- States:
  - IDLE -> ADDR on accept.
  - ADDR: beat 0 address phase, htrans = NONSEQ. Advances to BURST (N > 1) or LAST (N = 1) when hready = 1.
  - BURST: address phase of beat i overlaps data phase of beat i-1, htrans = SEQ. Advances to LAST after the final address is accepted with hready = 1.
  - LAST: final data phase only, htrans = IDLE. Goes to IDLE when hready = 1.
  - ERR: htrans = IDLE for one cycle, then IDLE.
- Beat count N: 1 / 4 / 4 / 8.
- Address of beat i, modulo 1024:
  - INCR: cmd_addr + i; rolls from 10'h3FF to 10'h000.
  - WRAP4: {cmd_addr[9:2], cmd_addr[1:0] + i[1:0]}.
- Address and control (haddr, htrans, hwrite, hburst) change only at edges where hready = 1. They hold while hready = 0.
- Write data:
  - wd_pop pulses in each cycle where a write address phase is accepted (hready = 1, htrans != IDLE, hwrite = 1).
  - wd_data is registered into hwdata at that edge and held until the data phase completes (hready = 1).
  - Exactly N pops per write command; none for reads.
- Read data:
  - At each edge ending a read data phase (hready = 1, hresp = 0), hrdata -> rd_data and rd_valid = 1 for the following cycle.
  - Exactly N rd_valid pulses per successful read.
- Completion: done = 1 (err = 0) in the cycle after the final data phase completes; coincides with the last rd_valid for reads.
- Latency with hready held at 1, command accepted at cycle T:
  - Beat i address phase at T+1+i; data phase at T+2+i.
  - done at T+2+N; cmd_ready returns at T+2+N.
- ERROR response (first cycle: hresp = 1, hready = 0):
  - At that edge the master replaces any pending address with htrans = IDLE (cancels remaining beats) and enters ERR.
  - The errored beat produces no rd_valid; no further wd_pop.
  - done = 1 with err = 1 in the cycle after the second error cycle (hresp = 1, hready = 1).
- Wait states on the final data phase extend LAST indefinitely.
- cmd_valid during a burst is ignored, since cmd_ready = 0.

Test Plan:
- Single write, hready = 1: cmd addr 0x005, data 0xA5 -> NONSEQ haddr 0x005 hburst 000 at T+1, hwdata 0xA5 at T+2, one wd_pop at T+1, done at T+3.
- INCR4 read at 0x3FE, slave returns 0x11, 0x22, 0x33, 0x44 -> haddr 3FE, 3FF, 000, 001 (NONSEQ, SEQ, SEQ, SEQ); four rd_valid pulses with those values; done at T+6 coinciding with the last rd_valid.
- WRAP4 write at 0x00E, data 1, 2, 3, 4 -> haddr 00E, 00F, 00C, 00D, hburst 010, four wd_pops; hwdata sequence 1, 2, 3, 4.
- INCR8 read with hready low for 2 cycles during beat 3 data phase -> haddr and hrdata capture hold during the wait; still 8 rd_valid pulses; done delayed 2 cycles to T+12.
- INCR4 write, slave gives ERROR on beat 1 -> htrans IDLE at the edge after the first error cycle, no SEQ for beats 2 and 3, exactly 2 wd_pops, done with err = 1 after the second error cycle.
- hreset asserted mid-INCR8 -> htrans = 00 and haddr = 0 on the next edge, no done; after release a new SINGLE completes normally.
